// File: rtl/window_pos_queue_pkg.sv
// Shared types and width helpers for the window position queue.
// win_pos_t uses the default geometry; the top rebuilds the struct from its own parameters.
package window_pos_queue_pkg;

  function automatic int calc_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  localparam int IMG_WIDTH_DEF  = 45;
  localparam int IMG_HEIGHT_DEF = 45;
  localparam int W_SCALE_DEF    = 3;
  localparam int W_X_DEF        = calc_width(IMG_WIDTH_DEF);
  localparam int W_Y_DEF        = calc_width(IMG_HEIGHT_DEF);

  typedef struct packed {
    logic                   eot;
    logic [W_SCALE_DEF-1:0] scale;
    logic [W_Y_DEF-1:0]     y;
    logic [W_X_DEF-1:0]     x;
  } win_pos_t;

endpackage

// File: rtl/window_pos_queue_pos_fifo.sv
// Small register-based FIFO holding window positions awaiting a classifier result.
// The head entry is read combinationally so it can be paired in the same cycle as the result.
module window_pos_queue_pos_fifo
  import window_pos_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = win_pos_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int W_PTR = $clog2(DEPTH);
  localparam int W_LVL = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [W_PTR-1:0] r_wr_ptr;
  logic [W_PTR-1:0] r_rd_ptr;
  logic [W_LVL-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == W_LVL'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/window_pos_queue.sv
// Pairs in-order classifier results with queued window positions and emits detection beats,
// one per hit plus a closing beat per frame carrying the frame's hit count.
module window_pos_queue
  import window_pos_queue_pkg::*;
#(
  parameter int  IMG_WIDTH  = 45,
  parameter int  IMG_HEIGHT = 45,
  parameter int  DEPTH      = 4,
  parameter int  W_SCALE    = 3,
  parameter int  W_CNT      = 16,
  localparam int W_X        = calc_width(IMG_WIDTH),
  localparam int W_Y        = calc_width(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_window_pos_valid,
  output logic               o_window_pos_ready,
  input  logic               i_window_pos_eot,
  input  logic [W_X-1:0]     i_window_pos_x,
  input  logic [W_Y-1:0]     i_window_pos_y,
  input  logic [W_SCALE-1:0] i_window_pos_scale,
  input  logic               i_result_valid,
  output logic               o_result_ready,
  input  logic               i_result,
  output logic               o_detect_pos_valid,
  input  logic               i_detect_pos_ready,
  output logic               o_detect_pos_eot,
  output logic               o_detect_pos_hit,
  output logic [W_X-1:0]     o_detect_pos_x,
  output logic [W_Y-1:0]     o_detect_pos_y,
  output logic [W_SCALE-1:0] o_detect_pos_scale,
  output logic [W_CNT-1:0]   o_detect_count
);

  typedef struct packed {
    logic               eot;
    logic [W_SCALE-1:0] scale;
    logic [W_Y-1:0]     y;
    logic [W_X-1:0]     x;
  } pos_t;

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  pos_t             w_wr_entry;
  pos_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_fire;
  logic             w_load;
  logic [W_CNT-1:0] w_cnt_sum;

  logic               r_valid;
  logic               r_eot;
  logic               r_hit;
  logic [W_X-1:0]     r_x;
  logic [W_Y-1:0]     r_y;
  logic [W_SCALE-1:0] r_scale;
  logic [W_CNT-1:0]   r_count;
  logic [W_CNT-1:0]   r_hit_cnt;

  assign w_wr_entry = '{eot: i_window_pos_eot, scale: i_window_pos_scale,
                        y: i_window_pos_y, x: i_window_pos_x};

  window_pos_queue_pos_fifo #(
    .DEPTH (DEPTH),
    .T     (pos_t)
  ) u_pos_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_window_pos_valid),
    .i_data  (w_wr_entry),
    .i_pop   (w_fire),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Result is only taken when the output slot is free or draining this cycle.
  assign o_window_pos_ready = !w_full;
  assign o_result_ready     = !w_empty && (!r_valid || i_detect_pos_ready);
  assign w_fire             = i_result_valid && o_result_ready;
  assign w_load             = w_fire && (i_result || w_head.eot);
  assign w_cnt_sum          = (i_result && (r_hit_cnt != CNT_MAX)) ? r_hit_cnt + 1'b1 : r_hit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_eot   <= 1'b0;
      r_hit   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_scale <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_eot   <= w_head.eot;
      r_hit   <= i_result;
      r_x     <= w_head.x;
      r_y     <= w_head.y;
      r_scale <= w_head.scale;
      if (w_head.eot) r_count <= w_cnt_sum;
    end else if (i_detect_pos_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (w_fire) begin
      r_hit_cnt <= w_head.eot ? '0 : w_cnt_sum;
    end
  end

  assign o_detect_pos_valid = r_valid;
  assign o_detect_pos_eot   = r_eot;
  assign o_detect_pos_hit   = r_hit;
  assign o_detect_pos_x     = r_x;
  assign o_detect_pos_y     = r_y;
  assign o_detect_pos_scale = r_scale;
  assign o_detect_count     = r_count;

endmodule

// File: tb/tb_window_pos_queue.sv
// Directed bench for window_pos_queue: pairing, full/empty limits, backpressure,
// count saturation (W_CNT=2) and reset mid-frame.
module tb_window_pos_queue;

  logic       clk;
  logic       rst;
  logic       wv, wready, weot;
  logic [5:0] wx, wy;
  logic [2:0] ws;
  logic       rv, rready, res;
  logic       dv, dr, deot, dhit;
  logic [5:0] dx, dy;
  logic [2:0] ds;
  logic [1:0] dcnt;

  int total = 0;
  int bad   = 0;

  window_pos_queue #(
    .IMG_WIDTH (45),
    .IMG_HEIGHT(45),
    .DEPTH     (4),
    .W_SCALE   (3),
    .W_CNT     (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_window_pos_valid (wv),
    .o_window_pos_ready (wready),
    .i_window_pos_eot   (weot),
    .i_window_pos_x     (wx),
    .i_window_pos_y     (wy),
    .i_window_pos_scale (ws),
    .i_result_valid     (rv),
    .o_result_ready     (rready),
    .i_result           (res),
    .o_detect_pos_valid (dv),
    .i_detect_pos_ready (dr),
    .o_detect_pos_eot   (deot),
    .o_detect_pos_hit   (dhit),
    .o_detect_pos_x     (dx),
    .o_detect_pos_y     (dy),
    .o_detect_pos_scale (ds),
    .o_detect_count     (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wv = 0; weot = 0; wx = 0; wy = 0; ws = 0;
    rv = 0; res = 0; dr = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push_one(input logic [5:0] x, input logic [5:0] y, input logic eot);
    wv = 1; wx = x; wy = y; ws = 3'd2; weot = eot;
    tick();
    wv = 0; weot = 0;
  endtask

  task automatic fire_one(input logic r);
    rv = 1; res = r;
    tick();
    rv = 0; res = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    total++;
    if (dv !== 1'b0 || dcnt !== 2'd0 || wready !== 1'b1 || rready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b count=%0d wready=%b rready=%b, want 0 0 1 0", dv, dcnt, wready, rready);
    end
    tick();
    tick();
    rst = 0;
    $display("reset: valid=%b wready=%b rready=%b", dv, wready, rready);
  endtask

  task automatic test_basic();
    do_reset();
    wv = 1; wx = 3; wy = 4; ws = 3'd1; weot = 0;
    tick();
    wx = 5; wy = 6; ws = 3'd1; weot = 1;
    tick();
    wv = 0; weot = 0;
    rv = 1; res = 1;
    #1;
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL basic_rready: got %b want 1", rready);
    end
    tick();
    total++;
    if (dv !== 1 || dx !== 6'd3 || dy !== 6'd4 || ds !== 3'd1 || dhit !== 1 || deot !== 0) begin
      bad++;
      $display("FAIL basic_hit_beat: v=%b x=%0d y=%0d s=%0d hit=%b eot=%b, want 1 3 4 1 1 0", dv, dx, dy, ds, dhit, deot);
    end
    $display("basic hit beat: x=%0d y=%0d hit=%b eot=%b", dx, dy, dhit, deot);
    res = 0;
    tick();
    total++;
    if (dv !== 1 || dx !== 6'd5 || dy !== 6'd6 || dhit !== 0 || deot !== 1 || dcnt !== 2'd1) begin
      bad++;
      $display("FAIL basic_eot_beat: v=%b x=%0d y=%0d hit=%b eot=%b cnt=%0d, want 1 5 6 0 1 1", dv, dx, dy, dhit, deot, dcnt);
    end
    $display("basic eot beat: x=%0d y=%0d hit=%b eot=%b count=%0d", dx, dy, dhit, deot, dcnt);
    rv = 0;
    tick();
    total++;
    if (dv !== 0 || wready !== 1 || rready !== 0) begin
      bad++; $display("FAIL basic_drain: v=%b wready=%b rready=%b, want 0 1 0", dv, wready, rready);
    end
  endtask

  task automatic test_full();
    logic [5:0] exp_x [4];
    exp_x[0] = 6'd2; exp_x[1] = 6'd3; exp_x[2] = 6'd10; exp_x[3] = 6'd11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wv = 1; wx = 6'(i); wy = 6'(i); weot = 0;
      tick();
    end
    wx = 10; wy = 10;
    #1;
    total++;
    if (wready !== 1'b0) begin
      bad++; $display("FAIL full_ready: got %b want 0", wready);
    end
    rv = 1; res = 0;
    #1;
    total++;
    if (wready !== 1'b0 || rready !== 1'b1) begin
      bad++; $display("FAIL full_push_blocked_on_pop: wready=%b rready=%b, want 0 1", wready, rready);
    end
    tick();
    total++;
    if (wready !== 1'b1) begin
      bad++; $display("FAIL full_ready_after_pop: got %b want 1", wready);
    end
    tick();
    total++;
    if (wready !== 1'b1) begin
      bad++; $display("FAIL full_push_pop_level: wready=%b want 1", wready);
    end
    rv = 0; wx = 11; wy = 11;
    tick();
    wv = 0;
    total++;
    if (wready !== 1'b0) begin
      bad++; $display("FAIL full_refilled: wready=%b want 0", wready);
    end
    rv = 1; res = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dv !== 1 || dx !== exp_x[i] || dhit !== 1) begin
        bad++; $display("FAIL full_order_%0d: v=%b x=%0d hit=%b, want 1 %0d 1", i, dv, dx, dhit, exp_x[i]);
      end
      $display("full drain beat %0d: x=%0d", i, dx);
    end
    rv = 0;
    tick();
    total++;
    if (dv !== 0 || rready !== 0 || wready !== 1) begin
      bad++; $display("FAIL full_empty_after: v=%b rready=%b wready=%b, want 0 0 1", dv, rready, wready);
    end
  endtask

  task automatic test_empty();
    do_reset();
    rv = 1; res = 1;
    #1;
    total++;
    if (rready !== 1'b0) begin
      bad++; $display("FAIL empty_rready: got %b want 0", rready);
    end
    tick();
    total++;
    if (dv !== 1'b0) begin
      bad++; $display("FAIL empty_no_stale: valid=%b want 0", dv);
    end
    wv = 1; wx = 7; wy = 8; weot = 0;
    #1;
    total++;
    if (rready !== 1'b0) begin
      bad++; $display("FAIL empty_no_fallthrough: rready=%b want 0", rready);
    end
    tick();
    wv = 0;
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL empty_rready_next: rready=%b want 1", rready);
    end
    tick();
    rv = 0;
    total++;
    if (dv !== 1 || dx !== 6'd7 || dy !== 6'd8) begin
      bad++; $display("FAIL empty_pair: v=%b x=%0d y=%0d, want 1 7 8", dv, dx, dy);
    end
    $display("empty pair beat: x=%0d y=%0d", dx, dy);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_one(6'd1, 6'd2, 1'b0);
    push_one(6'd3, 6'd4, 1'b0);
    dr = 0; rv = 1; res = 1;
    tick();
    total++;
    if (dv !== 1 || dx !== 6'd1) begin
      bad++; $display("FAIL b2b_first: v=%b x=%0d, want 1 1", dv, dx);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (dv !== 1 || dx !== 6'd1 || dy !== 6'd2 || rready !== 0) begin
        bad++; $display("FAIL b2b_hold_%0d: v=%b x=%0d y=%0d rready=%b, want 1 1 2 0", i, dv, dx, dy, rready);
      end
    end
    dr = 1;
    #1;
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL b2b_release_rready: got %b want 1", rready);
    end
    tick();
    rv = 0;
    total++;
    if (dv !== 1 || dx !== 6'd3 || dy !== 6'd4) begin
      bad++; $display("FAIL b2b_second: v=%b x=%0d y=%0d, want 1 3 4", dv, dx, dy);
    end
    $display("b2b second beat: x=%0d y=%0d", dx, dy);
    tick();
    total++;
    if (dv !== 1'b0) begin
      bad++; $display("FAIL b2b_drop: valid=%b want 0", dv);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_one(6'(i), 6'(i), 1'b0);
      fire_one(1'b1);
    end
    push_one(6'd9, 6'd9, 1'b1);
    fire_one(1'b0);
    total++;
    if (dv !== 1 || deot !== 1 || dhit !== 0 || dcnt !== 2'd3) begin
      bad++; $display("FAIL sat_count: v=%b eot=%b hit=%b cnt=%0d, want 1 1 0 3", dv, deot, dhit, dcnt);
    end
    $display("sat frame eot: count=%0d", dcnt);
    push_one(6'd20, 6'd21, 1'b1);
    fire_one(1'b1);
    total++;
    if (dv !== 1 || deot !== 1 || dhit !== 1 || dcnt !== 2'd1 || dx !== 6'd20) begin
      bad++; $display("FAIL sat_next_frame: v=%b eot=%b hit=%b cnt=%0d x=%0d, want 1 1 1 1 20", dv, deot, dhit, dcnt, dx);
    end
    $display("next frame eot: count=%0d", dcnt);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(6'(i), 6'(i), 1'b0);
    dr = 0;
    fire_one(1'b1);
    total++;
    if (dv !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre_valid: valid=%b want 1", dv);
    end
    rst = 1;
    #1;
    total++;
    if (dv !== 0 || wready !== 1 || rready !== 0 || dcnt !== 2'd0) begin
      bad++; $display("FAIL rstmid_immediate: v=%b wready=%b rready=%b cnt=%0d, want 0 1 0 0", dv, wready, rready, dcnt);
    end
    tick();
    rst = 0; dr = 1;
    push_one(6'd30, 6'd31, 1'b1);
    fire_one(1'b0);
    total++;
    if (dv !== 1 || dx !== 6'd30 || deot !== 1 || dhit !== 0 || dcnt !== 2'd0) begin
      bad++; $display("FAIL rstmid_next_frame: v=%b x=%0d eot=%b hit=%b cnt=%0d, want 1 30 1 0 0", dv, dx, deot, dhit, dcnt);
    end
    $display("after reset frame: x=%0d count=%0d", dx, dcnt);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
